color_detect_mul_arbiter: RTL and testbench

COLOR_DETECT_MUL_ARBITER -- requirements
Module: color_detect_mul_arbiter

---
 rtl/color_detect_mul_arb_pkg.sv | 19 +
 rtl/color_detect_rr_arbiter.sv | 50 +++++
 rtl/color_detect_mul_arbiter.sv | 123 ++++++++++++
 tb/tb_color_detect_mul_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_detect_mul_arb_pkg.sv
// Shared widths, default multiplier latency and shadow-stage type for the
// shared-multiplier arbiter (color_detect_mul_arbiter).
package color_detect_mul_arb_pkg;

  localparam int OPND_W      = 16;
  localparam int PROD_W      = 32;
  localparam int MUL_LAT_DEF = 3;
  localparam int IDX_W       = 3;   // wide enough for up to 8 requesters

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } shadow_t;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/color_detect_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, wrapping
// around; grants nothing while i_en is low.
module color_detect_rr_arbiter
  import color_detect_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic             w_hi_found;
  logic [IDX_W-1:0] w_hi_idx;
  logic             w_lo_found;
  logic [IDX_W-1:0] w_lo_idx;

  // NOTE: every variable written here gets a default before any conditional
  // assignment; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IDX_W'(i);
        if (IDX_W'(i) >= i_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign o_valid = i_en && w_lo_found;
  assign o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = o_valid && (o_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/color_detect_mul_arbiter.sv
// Shares one pipelined 16x16 multiplier among NUM_REQ requesters; a shadow
// pipeline routes each product back. Define COLOR_DETECT_MUL_ARB_STATS_EN for counters.
module color_detect_mul_arbiter
  import color_detect_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OPND_W-1:0] req_a,
  input  logic [NUM_REQ*OPND_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [PROD_W-1:0]         rsp_p,
  output logic                      mul_ce,
  output logic                      mul_reset,
  output logic [OPND_W-1:0]         mul_din0,
  output logic [OPND_W-1:0]         mul_din1,
  input  logic [PROD_W-1:0]         mul_dout,
  output logic [31:0]               stat_issue_cnt,
  output logic [31:0]               stat_stall_cnt
);

  shadow_t          r_shadow [MUL_LAT];
  logic [IDX_W-1:0] r_ptr;

  shadow_t          w_tail;
  logic             w_tail_ready;
  logic             w_arb_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_grant_vld;

  assign w_tail    = r_shadow[MUL_LAT-1];
  // A held tail freezes the multiplier and shadow together; reset forces a flush.
  assign mul_ce    = reset || !w_tail.valid || w_tail_ready;
  assign mul_reset = reset;
  assign w_arb_en  = mul_ce && !reset;
  assign rsp_p     = mul_dout;
  assign req_ready = w_grant & req_valid;

  color_detect_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_valid (w_grant_vld)
  );

  always_comb begin
    w_tail_ready = 1'b0;
    rsp_valid    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_tail.idx == IDX_W'(i)) begin
        w_tail_ready = rsp_ready[i];
        rsp_valid[i] = w_tail.valid && !reset;
      end
    end
  end

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        mul_din0 = req_a[i*OPND_W +: OPND_W];
        mul_din1 = req_b[i*OPND_W +: OPND_W];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its neighbour's pre-edge value. The shadow stages are only a few flops, so
  // they reset whole; a wide data memory would reset just its valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < MUL_LAT; s++) begin
        r_shadow[s] <= '0;
      end
      r_ptr <= '0;
    end else if (mul_ce) begin
      r_shadow[0] <= '{valid: w_grant_vld, idx: w_grant_idx};
      for (int s = 1; s < MUL_LAT; s++) begin
        r_shadow[s] <= r_shadow[s-1];
      end
      if (w_grant_vld) begin
        r_ptr <= next_ptr(w_grant_idx, NUM_REQ);
      end
    end
  end

`ifdef COLOR_DETECT_MUL_ARB_STATS_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_grant_vld && (r_issue_cnt != '1)) begin
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
      if (w_tail.valid && !mul_ce && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign stat_issue_cnt = r_issue_cnt;
  assign stat_stall_cnt = r_stall_cnt;
`else
  assign stat_issue_cnt = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_color_detect_mul_arbiter.sv
// Scoreboard bench for color_detect_mul_arbiter: a queue-based reference model
// predicts grants, result timing and products; a negedge monitor compares.
module tb_color_detect_mul_arbiter;
  import color_detect_mul_arb_pkg::*;

  localparam int N   = 4;
  localparam int LAT = MUL_LAT_DEF;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*16-1:0]   req_a;
  logic [N*16-1:0]   req_b;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [31:0]       rsp_p;
  logic              mul_ce;
  logic              mul_reset;
  logic [15:0]       mul_din0;
  logic [15:0]       mul_din1;
  logic [31:0]       mul_dout;
  logic [31:0]       stat_issue_cnt;
  logic [31:0]       stat_stall_cnt;

  logic [15:0]       opa [N];
  logic [15:0]       opb [N];

  color_detect_mul_arbiter #(
    .NUM_REQ (N),
    .MUL_LAT (LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_p          (rsp_p),
    .mul_ce         (mul_ce),
    .mul_reset      (mul_reset),
    .mul_din0       (mul_din0),
    .mul_din1       (mul_din1),
    .mul_dout       (mul_dout),
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16] = opa[i];
      req_b[i*16 +: 16] = opb[i];
    end
  end

  // External LAT-stage multiplier with clock enable.
  logic [31:0] mpipe [LAT];
  always @(posedge clk) begin
    if (mul_reset) begin
      for (int k = 0; k < LAT; k++) mpipe[k] <= '0;
    end else if (mul_ce) begin
      mpipe[0] <= {16'b0, mul_din0} * {16'b0, mul_din1};
      for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
  end
  assign mul_dout = mpipe[LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference model: in-flight operations in issue order, each stamped with the
  // count of enabled clock edges at issue; it reaches the tail LAT-1 edges later.
  typedef struct { int idx; logic [31:0] p; int adv; } op_t;
  typedef struct { int idx; logic [31:0] p; } sb_t;
  op_t         infl [$];
  sb_t         sb   [$];
  int          ptr_m      = 0;
  int          adv_cnt    = 0;
  int          last_grant = -1;
  logic [31:0] m_issue    = '0;
  logic [31:0] m_stall    = '0;

  function automatic void predict(output bit tv, output int ti, output bit ce, output int g);
    tv = 1'b0;
    ti = 0;
    g  = -1;
    if (!reset && infl.size() > 0 && (adv_cnt - infl[0].adv) == LAT - 1) begin
      tv = 1'b1;
      ti = infl[0].idx;
    end
    ce = reset || !tv || (((rsp_ready >> ti) & 1) != 0);
    if (ce && !reset) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      end
    end
  endfunction

  initial begin
    bit tv, ce;
    int ti, g;
    logic [31:0] prod;
    forever begin
      @(posedge clk);
      predict(tv, ti, ce, g);
      last_grant = -1;
      if (reset) begin
        infl.delete();
        sb.delete();
        ptr_m   = 0;
        m_issue = '0;
        m_stall = '0;
      end else begin
        if (tv && !ce) m_stall++;
        if (ce) begin
          adv_cnt++;
          if (tv) void'(infl.pop_front());
          if (g >= 0) begin
            prod = 32'(opa[g]) * 32'(opb[g]);
            infl.push_back('{g, prod, adv_cnt});
            sb.push_back('{g, prod});
            ptr_m      = (g + 1) % N;
            m_issue++;
            last_grant = g;
          end
        end
      end
    end
  end

  // Monitor: compares every DUT output against the model once per cycle and
  // retires scoreboard entries on each accepted response.
  initial begin
    bit tv, ce;
    int ti, g;
    sb_t s;
    forever begin
      @(negedge clk);
      predict(tv, ti, ce, g);
      check("rsp_valid", rsp_valid, tv ? onehot(ti) : '0);
      check("mul_ce", mul_ce, ce);
      check("mul_reset", mul_reset, reset);
      if (g >= 0) begin
        check("req_ready", req_ready, onehot(g));
        check("mul_din0", mul_din0, opa[g]);
        check("mul_din1", mul_din1, opb[g]);
      end else begin
        check("req_ready_idle", req_ready, '0);
        check("mul_din0_idle", mul_din0, '0);
        check("mul_din1_idle", mul_din1, '0);
      end
      if (tv) check("rsp_p_tail", rsp_p, infl[0].p);
      if ((rsp_valid & rsp_ready) != '0) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: rsp_valid=%b with no outstanding operation", rsp_valid);
        end else begin
          s = sb.pop_front();
          check("sb_rsp_dest", rsp_valid, onehot(s.idx));
          check("sb_rsp_p", rsp_p, s.p);
        end
      end
`ifdef COLOR_DETECT_MUL_ARB_STATS_EN
      check("stat_issue", stat_issue_cnt, m_issue);
      check("stat_stall", stat_stall_cnt, m_stall);
`else
      check("stat_issue_off", stat_issue_cnt, '0);
      check("stat_stall_off", stat_stall_cnt, '0);
`endif
    end
  end

  typedef enum {ONE_SHOT, REFILL, HOLD} mode_e;
  mode_e mode = ONE_SHOT;

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (last_grant >= 0) begin
      case (mode)
        ONE_SHOT: req_valid[last_grant] = 1'b0;
        REFILL: begin
          opa[last_grant]       = rnd16();
          opb[last_grant]       = rnd16();
          req_valid[last_grant] = ($urandom_range(0, 3) != 0);
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    logic [31:0] stall_base;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    repeat (3) step();
    reset = 1'b0;

    // Single operation: 300*200 from requester 1, result LAT cycles later.
    step();
    step();
    opa[1] = 16'd300; opb[1] = 16'd200; req_valid[1] = 1'b1;
    @(negedge clk);
    check("d1_grant", req_ready, 4'b0010);
    repeat (LAT) step();
    @(negedge clk);
    check("d1_rsp_valid", rsp_valid, 4'b0010);
    check("d1_rsp_p", rsp_p, 32'd60000);

    // All requesters valid out of reset: grants 0,1,2,3,0 and results in order.
    step();
    mode = HOLD;
    reset = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      opa[i] = 16'(i + 1);
      opb[i] = 16'(100 * (i + 1));
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 5 + LAT; k++) begin
      @(negedge clk);
      if (k < 5) check("rr_grant", req_ready, onehot(k % N));
      if (k >= LAT) check("rr_rsp_order", rsp_valid, onehot((k - LAT) % N));
      step();
      if (k == 4) req_valid = '0;
    end
    mode = ONE_SHOT;

    // Largest operands: full 32-bit product.
    opa[2] = 16'hFFFF; opb[2] = 16'hFFFF; req_valid[2] = 1'b1;
    @(negedge clk);
    check("max_grant", req_ready, 4'b0100);
    repeat (LAT) step();
    @(negedge clk);
    check("max_rsp_valid", rsp_valid, 4'b0100);
    check("max_rsp_p", rsp_p, 32'hFFFE0001);

    // Backpressure: requester 0's result held for 5 cycles.
    step();
    rsp_ready = 4'b1110;
    opa[0] = 16'd1234; opb[0] = 16'd567; req_valid[0] = 1'b1;
    repeat (LAT) step();
    stall_base = m_stall;
    opa[3] = 16'd7; opb[3] = 16'd9; req_valid[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_mul_ce", mul_ce, 1'b0);
      check("stall_req_ready", req_ready, '0);
      check("stall_rsp_valid", rsp_valid, 4'b0001);
      check("stall_rsp_p", rsp_p, 32'd699678);
      step();
    end
    rsp_ready = '1;
`ifdef COLOR_DETECT_MUL_ARB_STATS_EN
    @(negedge clk);
    check("stall_cnt_delta", stat_stall_cnt, stall_base + 32'd5);
`endif
    repeat (LAT + 2) step();

    // Reset with three operations in flight: they never respond.
    req_valid = 4'b1110;
    for (int i = 0; i < N; i++) begin
      opa[i] = 16'(i + 11);
      opb[i] = 16'(i + 21);
    end
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("flush_rsp_valid", rsp_valid, '0);
      step();
    end
    req_valid = '1;
    @(negedge clk);
    check("post_reset_grant", req_ready, 4'b0001);

    // Randomized traffic with random result backpressure.
    mode = REFILL;
    repeat (3000) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          opa[i]       = rnd16();
          opb[i]       = rnd16();
          req_valid[i] = 1'b1;
        end
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
    end

    mode      = ONE_SHOT;
    req_valid = '0;
    rsp_ready = '1;
    repeat (LAT + 4) step();
    @(negedge clk);
    check("drain_outstanding", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
